// File: rtl/btn_to_dir_pkg.sv
// Shared definitions for the button-to-direction path: direction codes,
// FSM state type and the lowest-set-index priority encoder.
package btn_to_dir_pkg;

   // Direction codes line up with the one-hot LED encoding: bit i <-> code i.
   localparam logic [1:0] DIR_0 = 2'd0;
   localparam logic [1:0] DIR_1 = 2'd1;
   localparam logic [1:0] DIR_2 = 2'd2;
   localparam logic [1:0] DIR_3 = 2'd3;

   typedef enum logic {
      IDLE = 1'b0,
      HELD = 1'b1
   } state_t;

   function automatic logic [1:0] lowest_dir(input logic [3:0] v);
      logic [1:0] d;
      if (v[0])      d = DIR_0;
      else if (v[1]) d = DIR_1;
      else if (v[2]) d = DIR_2;
      else           d = DIR_3;
      return d;
   endfunction

endpackage

// File: rtl/btn_to_dir_debounce.sv
// Two-flop synchroniser plus whole-vector debounce: a new vector is accepted
// only after it has stayed unchanged for DEBOUNCE_CYCLES clocks.
module btn_debounce #(
   parameter  int unsigned WIDTH           = 4,
   parameter  int unsigned DEBOUNCE_CYCLES = 250000,
   localparam int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [WIDTH-1:0] i_raw,
   output logic [WIDTH-1:0] o_stable,
   output logic             o_busy
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] r_meta;
   logic [WIDTH-1:0] r_sync;
   logic [WIDTH-1:0] r_cand;
   logic [WIDTH-1:0] r_stable;
   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_meta   <= '0;
         r_sync   <= '0;
         r_cand   <= '0;
         r_stable <= '0;
         r_cnt    <= '0;
      end else begin
         r_meta <= i_raw;
         r_sync <= r_meta;
         // Any movement of the synchronised vector restarts qualification.
         if (r_sync != r_cand) begin
            r_cand <= r_sync;
            r_cnt  <= '0;
         end else if (r_cnt == CNT_MAX) begin
            r_stable <= r_cand;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   assign o_stable = r_stable;
   assign o_busy   = (r_cand != r_stable);

endmodule

// File: rtl/btn_to_dir.sv
// Debounced four-button input to 2-bit direction number, pressed flag and a
// one-cycle strobe on each new direction command.
module btn_to_dir
   import btn_to_dir_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] btn,
   output logic [1:0] num,
   output logic       pressed,
   output logic       dir_strobe,
   output logic       busy
);

   logic [3:0] w_stable;
   logic       w_busy;

   btn_debounce #(
      .WIDTH           (4),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_debounce (
      .i_clk    (clk),
      .i_rst_n  (rst_n),
      .i_raw    (btn),
      .o_stable (w_stable),
      .o_busy   (w_busy)
   );

   state_t     r_state;
   logic [1:0] r_num;
   logic       r_pressed;
   logic       r_strobe;

   state_t     w_state_nxt;
   logic [1:0] w_num_nxt;
   logic       w_pressed_nxt;
   logic       w_strobe_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_num     <= DIR_0;
         r_pressed <= 1'b0;
         r_strobe  <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_num     <= w_num_nxt;
         r_pressed <= w_pressed_nxt;
         r_strobe  <= w_strobe_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_num_nxt     = r_num;
      w_pressed_nxt = r_pressed;
      w_strobe_nxt  = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_stable != 4'b0000) begin
               w_state_nxt   = HELD;
               w_num_nxt     = lowest_dir(w_stable);
               w_pressed_nxt = 1'b1;
               w_strobe_nxt  = 1'b1;
            end
         end
         HELD: begin
            // The held direction keeps priority while its button stays down.
            if (w_stable == 4'b0000) begin
               w_state_nxt   = IDLE;
               w_pressed_nxt = 1'b0;
            end else if (!w_stable[r_num]) begin
               w_num_nxt    = lowest_dir(w_stable);
               w_strobe_nxt = 1'b1;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   assign num        = r_num;
   assign pressed    = r_pressed;
   assign dir_strobe = r_strobe;
   assign busy       = w_busy;

endmodule

// File: tb/tb_btn_to_dir.sv
// Scoreboard bench for btn_to_dir: a sampled-input model predicts output
// events, which are queued with their due edge and compared every cycle.
module tb_btn_to_dir;

   localparam int unsigned DEB = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] btn;
   logic [1:0] num;
   logic       pressed;
   logic       dir_strobe;
   logic       busy;

   always #5 clk = ~clk;

   btn_to_dir #(.DEBOUNCE_CYCLES(DEB)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .btn        (btn),
      .num        (num),
      .pressed    (pressed),
      .dir_strobe (dir_strobe),
      .busy       (busy)
   );

   typedef struct {
      int unsigned due;
      logic [1:0]  num;
      logic        pressed;
      logic        strobe;
   } ev_t;

   ev_t         sb_q[$];
   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   int unsigned cyc   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [1:0] low_idx(input logic [3:0] v);
      for (int i = 0; i < 4; i++) if (v[i]) return 2'(i);
      return 2'd0;
   endfunction

   // Model state: raw-input run tracking plus the predicted FSM state.
   logic [3:0]  run_val, m_stable, smp_btn;
   int unsigned run_len;
   logic        m_held, m_pressed, smp_rst;
   logic [1:0]  m_num;
   logic [1:0]  exp_num;
   logic        exp_pressed, exp_strobe;

   task automatic model_reset();
      run_val = 4'b0000; run_len = DEB + 1; m_stable = 4'b0000;
      m_held = 1'b0; m_num = 2'd0; m_pressed = 1'b0;
      exp_num = 2'd0; exp_pressed = 1'b0;
      sb_q.delete();
   endtask

   task automatic push(input logic strobe);
      ev_t ev;
      ev.due = cyc + 3; ev.num = m_num; ev.pressed = m_pressed; ev.strobe = strobe;
      sb_q.push_back(ev);
   endtask

   always begin
      ev_t ev;
      @(posedge clk);
      cyc++;
      smp_btn = btn;
      smp_rst = rst_n;
      #1;
      if (!smp_rst) begin
         model_reset();
         check("rst_num", 32'(num), 32'd0);
         check("rst_pressed", 32'(pressed), 32'd0);
         check("rst_strobe", 32'(dir_strobe), 32'd0);
         check("rst_busy", 32'(busy), 32'd0);
      end else begin
         if (smp_btn == run_val) run_len++;
         else begin run_val = smp_btn; run_len = 1; end
         // A vector present on DEB+1 consecutive sampling edges is accepted.
         if (run_len == DEB + 1 && run_val != m_stable) begin
            m_stable = run_val;
            if (m_stable == 4'b0000) begin
               if (m_held) begin m_held = 1'b0; m_pressed = 1'b0; push(1'b0); end
            end else if (!m_held) begin
               m_held = 1'b1; m_pressed = 1'b1; m_num = low_idx(m_stable); push(1'b1);
            end else if (!m_stable[m_num]) begin
               m_num = low_idx(m_stable); push(1'b1);
            end
         end
         exp_strobe = 1'b0;
         if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
            ev = sb_q.pop_front();
            exp_num = ev.num; exp_pressed = ev.pressed; exp_strobe = ev.strobe;
         end
         check("num", 32'(num), 32'(exp_num));
         check("pressed", 32'(pressed), 32'(exp_pressed));
         check("strobe", 32'(dir_strobe), 32'(exp_strobe));
      end
   end

   task automatic drive(input logic [3:0] b, input int unsigned n);
      btn = b;
      repeat (n) @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0;
      btn   = 4'b0000;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      drive(4'b0000, 20);

      // Single press: busy window and output edge relative to first sample.
      btn = 4'b0100;
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk); #2;
         if (k == 2)           check("busy_pre", 32'(busy), 32'd0);
         if (k >= 3 && k <= 6) check("busy_win", 32'(busy), 32'd1);
         if (k == 7) begin
            check("busy_post", 32'(busy), 32'd0);
            check("pressed_e7", 32'(pressed), 32'd0);
         end
         if (k == 8) begin
            check("pressed_e8", 32'(pressed), 32'd1);
            check("num_e8", 32'(num), 32'd2);
         end
      end
      @(negedge clk);
      drive(4'b0100, 8);
      drive(4'b0000, 12);

      // Glitchy press never qualifies until it settles.
      for (int g = 0; g < 5; g++) begin
         drive(4'b0010, 3);
         drive(4'b0000, 3);
      end
      drive(4'b0010, 15);
      drive(4'b0000, 12);

      // First-pressed wins, then a change of direction while held.
      drive(4'b0100, 12);
      drive(4'b0101, 12);
      drive(4'b0001, 12);
      drive(4'b0000, 12);

      // Simultaneous press resolves to lowest index; release keeps num.
      drive(4'b1010, 12);
      drive(4'b0000, 12);

      // Asynchronous reset while held, then re-qualification.
      drive(4'b1000, 12);
      rst_n = 1'b0;
      #1;
      check("arst_num", 32'(num), 32'd0);
      check("arst_pressed", 32'(pressed), 32'd0);
      check("arst_strobe", 32'(dir_strobe), 32'd0);
      check("arst_busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(4'b1000, 12);
      drive(4'b0000, 12);

      // Random segments of varying length, some too short to qualify.
      for (int r = 0; r < 60; r++) begin
         drive(4'($urandom_range(0, 15)), $urandom_range(1, 9));
      end
      drive(4'b0000, 15);

      check("sb_drain", 32'(sb_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
